// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode map, controller state encoding and the control vector.
// OPC_W is also used by the instruction register and the ALU.
package cpu_pkg;

    localparam int OPC_W   = 3;
    localparam int CYC_LEN = 8;

    localparam logic [OPC_W-1:0] HLT  = 3'b000;
    localparam logic [OPC_W-1:0] SKZ  = 3'b001;
    localparam logic [OPC_W-1:0] ADD  = 3'b010;
    localparam logic [OPC_W-1:0] ANDD = 3'b011;
    localparam logic [OPC_W-1:0] XORR = 3'b100;
    localparam logic [OPC_W-1:0] LDA  = 3'b101;
    localparam logic [OPC_W-1:0] STO  = 3'b110;
    localparam logic [OPC_W-1:0] JMP  = 3'b111;

    typedef enum logic [3:0] {
        S0   = 4'd0,
        S1   = 4'd1,
        S2   = 4'd2,
        S3   = 4'd3,
        S4   = 4'd4,
        S5   = 4'd5,
        S6   = 4'd6,
        S7   = 4'd7,
        HALT = 4'd8
    } state_t;

    typedef struct packed {
        logic load_ir;
        logic rd;
        logic wr;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
        logic halt;
    } ctl_t;

    function automatic logic is_alu(input logic [OPC_W-1:0] opc);
        return (opc == ADD) || (opc == ANDD) || (opc == XORR) || (opc == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decode of (state being entered, opcode, zlatch) into the control vector.
// The top level registers the result so outputs line up with the state they belong to.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t           i_state,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_zlatch,
    output ctl_t             o_ctl
);

    logic w_alu;
    logic w_sto;
    logic w_jmp;
    logic w_skip;

    assign w_alu  = is_alu(i_opcode);
    assign w_sto  = (i_opcode == STO);
    assign w_jmp  = (i_opcode == JMP);
    assign w_skip = (i_opcode == SKZ) && i_zlatch;

    always_comb begin
        o_ctl = '0;
        unique case (i_state)
            S0, S1: begin
                o_ctl.load_ir = 1'b1;
                o_ctl.rd      = 1'b1;
                o_ctl.inc_pc  = 1'b1;
            end
            S4: begin
                o_ctl.rd          = w_alu;
                o_ctl.datactl_ena = w_sto;
                o_ctl.load_pc     = w_jmp;
                o_ctl.inc_pc      = w_skip;
            end
            S5: begin
                o_ctl.rd          = w_alu;
                o_ctl.load_acc    = w_alu;
                o_ctl.wr          = w_sto;
                o_ctl.datactl_ena = w_sto;
                o_ctl.load_pc     = w_jmp;
                o_ctl.inc_pc      = w_skip;
            end
            S6: o_ctl.datactl_ena = w_sto;
            HALT: o_ctl.halt = 1'b1;
            default: o_ctl = '0;
        endcase
    end

endmodule

// File: rtl/cpu_machine_ctrl.sv
// Instruction-cycle controller: sequences each opcode through S0..S7 (or HALT) with registered outputs.
// Optional macro CPU_HALT_RESUME_EN adds a resume input that leaves HALT into a fresh fetch.
//
// state | meaning
// S0    | high byte fetch (idle when entered with ena low / after reset)
// S1    | low byte fetch
// S2    | decode
// S3    | HLT branches to HALT here
// S4    | operand phase 1, zero sampled into zlatch
// S5    | operand phase 2
// S6    | STO data hold
// S7    | end of cycle, back to S0
// HALT  | halted, ena ignored
module cpu_machine_ctrl
    import cpu_pkg::*;
(
    input  logic             clk1,
    input  logic             rst,
    input  logic             ena,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
`ifdef CPU_HALT_RESUME_EN
    input  logic             resume,
`endif
    output logic             load_ir,
    output logic             rd,
    output logic             wr,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             datactl_ena,
    output logic             halt
);

    state_t r_state;
    state_t w_next_state;
    ctl_t   r_ctl;
    ctl_t   w_dec;
    ctl_t   w_ctl;
    logic   r_zlatch;
    logic   w_zlatch_next;
    logic   w_run;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state  <= S0;
            r_ctl    <= '0;
            r_zlatch <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_ctl    <= w_ctl;
            r_zlatch <= w_zlatch_next;
        end
    end

    // S0 with load_ir low is the idle/reset condition; the next enabled edge re-enters S0 to fetch.
    always_comb begin
        w_next_state = r_state;
        w_run        = 1'b1;
        unique case (r_state)
            S0:      w_next_state = r_ctl.load_ir ? S1 : S0;
            S1:      w_next_state = S2;
            S2:      w_next_state = S3;
            S3:      w_next_state = (opcode == HLT) ? HALT : S4;
            S4:      w_next_state = S5;
            S5:      w_next_state = S6;
            S6:      w_next_state = S7;
            S7:      w_next_state = S0;
            HALT: begin
                w_next_state = HALT;
`ifdef CPU_HALT_RESUME_EN
                if (resume) begin
                    w_next_state = S0;
                end
`endif
            end
            default: w_next_state = S0;
        endcase
        if ((r_state != HALT) && !ena) begin
            w_next_state = S0;
            w_run        = 1'b0;
        end
    end

    // SKZ decides on the zero value seen at S4 entry, so feed that value straight to the decode.
    assign w_zlatch_next = (w_run && (w_next_state == S4)) ? zero : r_zlatch;

    cpu_ctrl_decode u_decode (
        .i_state  (w_next_state),
        .i_opcode (opcode),
        .i_zlatch (w_zlatch_next),
        .o_ctl    (w_dec)
    );

    assign w_ctl = w_run ? w_dec : '0;

    assign load_ir     = r_ctl.load_ir;
    assign rd          = r_ctl.rd;
    assign wr          = r_ctl.wr;
    assign inc_pc      = r_ctl.inc_pc;
    assign load_pc     = r_ctl.load_pc;
    assign load_acc    = r_ctl.load_acc;
    assign datactl_ena = r_ctl.datactl_ena;
    assign halt        = r_ctl.halt;

endmodule

// File: tb/tb_cpu_machine_ctrl.sv
// Self-checking bench for cpu_machine_ctrl: directed instruction scenarios plus random traffic
// compared every cycle against a cycle-position model of the instruction sequence.
module tb_cpu_machine_ctrl;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic       clk1 = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
`ifdef CPU_HALT_RESUME_EN
    logic       resume;
`endif
    logic load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;
    logic [7:0] dut_vec;

    assign dut_vec = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};

    always #5 clk1 = ~clk1;

    cpu_machine_ctrl dut (
        .clk1        (clk1),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
`ifdef CPU_HALT_RESUME_EN
        .resume      (resume),
`endif
        .load_ir     (load_ir),
        .rd          (rd),
        .wr          (wr),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model: where we are in the instruction (position 0..7), idle or halted
    bit m_active = 1'b0;
    bit m_halted = 1'b0;
    bit m_zl     = 1'b0;
    int m_pos    = 0;

    int cnt_ir, cnt_rd, cnt_wr, cnt_inc, cnt_pc, cnt_acc, cnt_dctl;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", tag, act, exp);
    endtask

    function automatic logic [7:0] model_vec();
        bit alu, sto, jmp, skz, fetch, mid, e_ir, e_rd, e_wr, e_inc, e_pc, e_acc, e_dc;
        alu   = (opcode >= 3'd2) && (opcode <= 3'd5);
        sto   = (opcode == OP_STO);
        jmp   = (opcode == OP_JMP);
        skz   = (opcode == OP_SKZ);
        fetch = m_active && (m_pos < 2);
        mid   = m_active && (m_pos == 4 || m_pos == 5);
        e_ir  = fetch;
        e_rd  = fetch || (mid && alu);
        e_wr  = m_active && sto && (m_pos == 5);
        e_inc = fetch || (mid && skz && m_zl);
        e_pc  = mid && jmp;
        e_acc = m_active && alu && (m_pos == 5);
        e_dc  = m_active && sto && (m_pos >= 4) && (m_pos <= 6);
        return {e_ir, e_rd, e_wr, e_inc, e_pc, e_acc, e_dc, m_halted};
    endfunction

    task automatic model_edge();
        if (m_halted) begin
`ifdef CPU_HALT_RESUME_EN
            if (resume) begin
                m_halted = 1'b0;
                m_active = 1'b1;
                m_pos    = 0;
            end
`endif
        end else if (!ena) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_pos    = 0;
        end else if (m_pos == 3 && opcode == OP_HLT) begin
            m_halted = 1'b1;
            m_active = 1'b0;
        end else begin
            m_pos = (m_pos + 1) % 8;
        end
        if (m_active && m_pos == 4) m_zl = zero;
    endtask

    task automatic step(input string tag);
        @(posedge clk1);
        model_edge();
        @(negedge clk1);
        cyc++;
        check_eq($sformatf("%s_c%0d", tag, cyc), dut_vec, model_vec());
        cnt_ir   += int'(load_ir);
        cnt_rd   += int'(rd);
        cnt_wr   += int'(wr);
        cnt_inc  += int'(inc_pc);
        cnt_pc   += int'(load_pc);
        cnt_acc  += int'(load_acc);
        cnt_dctl += int'(datactl_ena);
    endtask

    task automatic clear_counts();
        cnt_ir = 0; cnt_rd = 0; cnt_wr = 0; cnt_inc = 0;
        cnt_pc = 0; cnt_acc = 0; cnt_dctl = 0;
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_eq({tag, "_async"}, dut_vec, 8'h00);
        m_active = 1'b0;
        m_halted = 1'b0;
        m_zl     = 1'b0;
        m_pos    = 0;
        @(posedge clk1);
        @(negedge clk1);
        check_eq({tag, "_hold"}, dut_vec, 8'h00);
        rst = 1'b0;
    endtask

    // one full instruction from S0; zero is set explicitly for S4/S5 entry
    task automatic run_instr(input logic [2:0] op, input logic z4, input logic z5, input string tag);
        clear_counts();
        opcode = op;
        for (int k = 0; k < 8; k++) begin
            zero = (k == 4) ? z4 : (k == 5) ? z5 : 1'($urandom);
            step(tag);
        end
    endtask

    int halt_run;
    logic [2:0] op_r;

    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        opcode = OP_ADD;
        zero   = 1'b0;
`ifdef CPU_HALT_RESUME_EN
        resume = 1'b0;
`endif
        #1 check_eq("por", dut_vec, 8'h00);
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst = 1'b0;
        ena = 1'b1;

        run_instr(OP_ADD, 1'b0, 1'b0, "add");
        check_eq("add_ir_cnt",  8'(cnt_ir),  8'd2);
        check_eq("add_inc_cnt", 8'(cnt_inc), 8'd2);
        check_eq("add_rd_cnt",  8'(cnt_rd),  8'd4);
        check_eq("add_acc_cnt", 8'(cnt_acc), 8'd1);
        check_eq("add_wr_cnt",  8'(cnt_wr),  8'd0);

        run_instr(OP_STO, 1'b0, 1'b1, "sto");
        check_eq("sto_dctl_cnt", 8'(cnt_dctl), 8'd3);
        check_eq("sto_wr_cnt",   8'(cnt_wr),   8'd1);
        check_eq("sto_rd_cnt",   8'(cnt_rd),   8'd2);

        run_instr(OP_SKZ, 1'b1, 1'b0, "skz1");
        check_eq("skz1_inc_cnt", 8'(cnt_inc), 8'd4);
        run_instr(OP_SKZ, 1'b0, 1'b1, "skz0");
        check_eq("skz0_inc_cnt", 8'(cnt_inc), 8'd2);

        run_instr(OP_JMP, 1'b0, 1'b0, "jmp");
        check_eq("jmp_pc_cnt",  8'(cnt_pc),  8'd2);
        check_eq("jmp_inc_cnt", 8'(cnt_inc), 8'd2);
        opcode = OP_ADD;
        step("jmp_next");
        check_eq("jmp_next_s0", {7'd0, load_ir}, 8'd1);

        // rst asserted during S5 of an ADD (one S0 already entered above)
        for (int k = 1; k < 6; k++) step("add_pre_rst");
        check_eq("add_in_s5", {7'd0, load_acc}, 8'd1);
        do_reset("rst_s5");
        step("post_rst");
        check_eq("post_rst_fetch", {5'd0, load_ir, rd, inc_pc}, 8'b111);
        for (int k = 1; k < 8; k++) step("add_after_rst");

        opcode = OP_HLT;
        for (int k = 0; k < 5; k++) step("hlt");
        check_eq("hlt_at_c4", {7'd0, halt}, 8'd1);
        for (int k = 0; k < 22; k++) begin
            ena    = 1'($urandom);
            opcode = 3'($urandom);
            step("halt_hold");
        end
        ena = 1'b1;
`ifdef CPU_HALT_RESUME_EN
        resume = 1'b1;
        step("resume");
        resume = 1'b0;
        check_eq("resume_fetch", {6'd0, halt, load_ir}, 8'b01);
        opcode = OP_ADD;
        for (int k = 1; k < 8; k++) step("after_resume");
`else
        do_reset("hlt_exit");
`endif

        // random traffic
        halt_run = 0;
        for (int n = 0; n < 600; n++) begin
            if (!m_halted && (!m_active || m_pos == 7)) begin
                op_r = 3'($urandom);
                if (op_r == OP_HLT && $urandom_range(0, 3) != 0) op_r = OP_ADD;
                opcode = op_r;
            end
            ena  = ($urandom_range(0, 15) != 0);
            zero = 1'($urandom);
`ifdef CPU_HALT_RESUME_EN
            resume = m_halted && ($urandom_range(0, 3) == 0);
`endif
            halt_run = m_halted ? halt_run + 1 : 0;
            if ($urandom_range(0, 79) == 0 || halt_run > 10) begin
                do_reset("rnd_rst");
                halt_run = 0;
            end else begin
                step("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
